// File: rtl/j11_pkg.sv
// j11_pkg: shared state type, I/O-page base, GP cycle codes and powerup word for the J11 bus controller
package j11_pkg;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  localparam logic [21:0] IO_BASE    = 22'o17760000;
  localparam logic [7:0]  GP_PWRUP   = 8'o0;
  localparam logic [7:0]  GP_RST_SET = 8'o14;
  localparam logic [7:0]  GP_RST_CLR = 8'o214;
  localparam logic [7:0]  GP_ODT_SET = 8'o34;
  localparam logic [7:0]  GP_ODT_CLR = 8'o234;
  localparam logic [15:0] PWRUP_WORD = 16'o3;
endpackage

// File: rtl/j11_irqpri.sv
// j11_irqpri: rising-edge pending latches per channel, registered BR lines and a per-level priority encoder for IACK
module j11_irqpri #(
  parameter int NIRQ = 4,
  parameter logic [NIRQ*2-1:0] IRQLVL = '0,
  parameter logic [NIRQ*9-1:0] IRQVEC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NIRQ-1:0] irq,
  input  logic            iack,
  input  logic [3:0]      lvl_sel,
  output logic [8:0]      vec,
  output logic            hit,
  output logic [3:0]      j11irq
);
  logic [NIRQ-1:0] irq_q, pend_q, pend_d, cand, win;
  logic [3:0] j11irq_q, j11irq_d;
  assign j11irq = j11irq_q;
  always_comb begin
    cand = '0;
    vec = '0;
    j11irq_d = '0;
    for (int c = 0; c < NIRQ; c++) begin
      cand[c] = pend_q[c] & lvl_sel[IRQLVL[2*c +: 2]];
      j11irq_d[IRQLVL[2*c +: 2]] = j11irq_d[IRQLVL[2*c +: 2]] | pend_q[c];
    end
    win = cand & (~cand + NIRQ'(1));
    for (int c = 0; c < NIRQ; c++) vec = vec | (win[c] ? IRQVEC[9*c +: 9] : 9'd0);
    hit = |cand;
    // set after clear so an edge coinciding with its own IACK stays pending
    pend_d = (pend_q & ~(iack ? win : '0)) | (irq & ~irq_q);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q <= '0;
      pend_q <= '0;
      j11irq_q <= '0;
    end else begin
      irq_q <= irq;
      pend_q <= pend_d;
      j11irq_q <= j11irq_d;
    end
  end
endmodule

// File: rtl/j11bus_ctl.sv
// j11bus_ctl: J11 bus cycle controller decoding GP, IACK, memory and I/O-page device cycles with ack timeout
module j11bus_ctl import j11_pkg::*; #(
  parameter int NIRQ = 4,
  parameter int NDEV = 2,
  parameter logic [NDEV*13-1:0] DEVBASE = {13'o17560, 13'o17550},
  parameter logic [NIRQ*2-1:0] IRQLVL = '0,
  parameter logic [NIRQ*9-1:0] IRQVEC = {9'o64, 9'o60, 9'o64, 9'o60},
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              busreq,
  input  logic              buswr,
  input  logic              busgp,
  input  logic              busirq,
  input  logic [21:0]       busaddr,
  input  logic [15:0]       buswdata,
  output logic              busack,
  output logic              buserr,
  output logic [15:0]       busrdata,
  output logic              busrst,
  output logic              odt,
  output logic              memreq,
  input  logic              memack,
  input  logic [15:0]       memrdata,
  output logic [21:0]       memaddr,
  output logic [15:0]       memwdata,
  output logic              memwr,
  output logic [NDEV-1:0]   devreq,
  input  logic [NDEV-1:0]   devack,
  input  logic [16*NDEV-1:0] devrdata,
  output logic [3:0]        devaddr,
  output logic              devwr,
  output logic [15:0]       devwdata,
  input  logic [NIRQ-1:0]   irq,
  output logic [3:0]        j11irq
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busack_q, busack_d, buserr_q, buserr_d, memreq_q, memreq_d;
  logic mem_sel_q, mem_sel_d, busrst_q, busrst_d, odt_q, odt_d;
  logic [NDEV-1:0] devreq_q, devreq_d, dev_sel_q, dev_sel_d, dev_hit, dev_first;
  logic [15:0] busrdata_q, busrdata_d, dev_data;
  logic is_mem, start, iack, tgt_ack, vec_hit;
  logic [8:0] vec;
  logic [7:0] gp_code;
  assign memaddr = busaddr;
  assign memwdata = buswdata;
  assign memwr = buswr;
  assign devaddr = busaddr[4:1];
  assign devwr = buswr;
  assign devwdata = buswdata;
  assign busack = busack_q;
  assign buserr = buserr_q;
  assign busrdata = busrdata_q;
  assign busrst = busrst_q;
  assign odt = odt_q;
  assign memreq = memreq_q;
  assign devreq = devreq_q;
  assign is_mem = busaddr < IO_BASE;
  assign start = state_q == ST_IDLE && busreq;
  assign iack = start && !busgp && busirq;
  assign gp_code = busaddr[7:0];
  assign tgt_ack = mem_sel_q ? memack : |(devack & dev_sel_q);
  j11_irqpri #(.NIRQ(NIRQ), .IRQLVL(IRQLVL), .IRQVEC(IRQVEC)) u_irqpri (
    .clk(clk), .rstn(rstn), .irq(irq), .iack(iack), .lvl_sel(busaddr[3:0]),
    .vec(vec), .hit(vec_hit), .j11irq(j11irq)
  );
  always_comb begin
    dev_hit = '0;
    dev_data = '0;
    for (int d = 0; d < NDEV; d++) begin
      dev_hit[d] = !is_mem && busaddr[12:5] == DEVBASE[13*d+5 +: 8];
      dev_data = dev_data | (dev_sel_q[d] ? devrdata[16*d +: 16] : 16'd0);
    end
    dev_first = dev_hit & (~dev_hit + NDEV'(1));
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    busack_d = 1'b0;
    buserr_d = 1'b0;
    memreq_d = 1'b0;
    devreq_d = '0;
    mem_sel_d = mem_sel_q;
    dev_sel_d = dev_sel_q;
    busrdata_d = busrdata_q;
    busrst_d = busrst_q;
    odt_d = odt_q;
    if (start) begin
      if (busgp) begin
        busack_d = 1'b1;
        busrdata_d = (!buswr && gp_code == GP_PWRUP) ? PWRUP_WORD : 16'd0;
        busrst_d = !buswr ? busrst_q : gp_code == GP_RST_SET ? 1'b1 : gp_code == GP_RST_CLR ? 1'b0 : busrst_q;
        odt_d = !buswr ? odt_q : gp_code == GP_ODT_SET ? 1'b1 : gp_code == GP_ODT_CLR ? 1'b0 : odt_q;
      end else if (busirq) begin
        busack_d = 1'b1;
        busrdata_d = vec_hit ? {7'd0, vec} : 16'd0;
      end else if (is_mem || |dev_hit) begin
        memreq_d = is_mem;
        devreq_d = dev_first;
        mem_sel_d = is_mem;
        dev_sel_d = dev_first;
        cnt_d = '0;
        state_d = ST_BUSY;
      end else begin
        busack_d = 1'b1;
        buserr_d = 1'b1;
        busrdata_d = 16'd0;
      end
    end else if (state_q == ST_BUSY) begin
      if (tgt_ack || cnt_q == CNT_LAST) begin
        busack_d = 1'b1;
        buserr_d = !tgt_ack;
        busrdata_d = !tgt_ack ? 16'd0 : mem_sel_q ? memrdata : dev_data;
        state_d = ST_IDLE;
      end else cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      busack_q <= 1'b0;
      buserr_q <= 1'b0;
      memreq_q <= 1'b0;
      devreq_q <= '0;
      mem_sel_q <= 1'b0;
      dev_sel_q <= '0;
      busrdata_q <= '0;
      busrst_q <= 1'b1;
      odt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busack_q <= busack_d;
      buserr_q <= buserr_d;
      memreq_q <= memreq_d;
      devreq_q <= devreq_d;
      mem_sel_q <= mem_sel_d;
      dev_sel_q <= dev_sel_d;
      busrdata_q <= busrdata_d;
      busrst_q <= busrst_d;
      odt_q <= odt_d;
    end
  end
endmodule

// File: tb/tb_j11bus_ctl.sv
// tb_j11bus_ctl: randomized scenario tasks checked against a behavioural model of the J11 bus controller
module tb_j11bus_ctl;
  localparam int NIRQ = 4;
  localparam int NDEV = 2;
  localparam int TIMEOUT = 64;
  localparam logic [NDEV*13-1:0] DEVBASE = {13'o17560, 13'o17550};
  localparam logic [NIRQ*2-1:0] IRQLVL = {2'd3, 2'd1, 2'd0, 2'd0};
  localparam logic [NIRQ*9-1:0] IRQVEC = {9'o64, 9'o60, 9'o64, 9'o60};
  localparam logic [21:0] IOB = 22'o17760000;
  logic clk = 1'b0, rstn;
  logic busreq = 0, buswr = 0, busgp = 0, busirq = 0;
  logic [21:0] busaddr = '0;
  logic [15:0] buswdata = '0, busrdata, memrdata = '0, memwdata, devwdata;
  logic busack, buserr, busrst, odt, memreq, memack = 0, memwr, devwr;
  logic [21:0] memaddr;
  logic [NDEV-1:0] devreq, devack = '0;
  logic [16*NDEV-1:0] devrdata = '0;
  logic [3:0] devaddr, j11irq;
  logic [NIRQ-1:0] irq = '0;
  int n_chk = 0, n_fail = 0;
  bit pend[NIRQ];
  bit m_rst = 1, m_odt = 0;
  always #5 clk = ~clk;
  j11bus_ctl #(.NIRQ(NIRQ), .NDEV(NDEV), .DEVBASE(DEVBASE), .IRQLVL(IRQLVL), .IRQVEC(IRQVEC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .busreq(busreq), .buswr(buswr), .busgp(busgp), .busirq(busirq),
    .busaddr(busaddr), .buswdata(buswdata), .busack(busack), .buserr(buserr), .busrdata(busrdata),
    .busrst(busrst), .odt(odt), .memreq(memreq), .memack(memack), .memrdata(memrdata),
    .memaddr(memaddr), .memwdata(memwdata), .memwr(memwr), .devreq(devreq), .devack(devack),
    .devrdata(devrdata), .devaddr(devaddr), .devwr(devwr), .devwdata(devwdata), .irq(irq), .j11irq(j11irq)
  );
  function automatic int slot_of(input logic [21:0] a);
    if (a < IOB) return -1;
    for (int i = 0; i < NDEV; i++) if (((a - IOB) >> 5) == 22'(DEVBASE[13*i +: 13] >> 5)) return i;
    return -1;
  endfunction
  function automatic logic [3:0] lvl_exp();
    logic [3:0] r = '0;
    for (int c = 0; c < NIRQ; c++) if (pend[c]) r[IRQLVL[2*c +: 2]] = 1'b1;
    return r;
  endfunction
  function automatic int winner(input int l);
    for (int c = 0; c < NIRQ; c++) if (pend[c] && int'(IRQLVL[2*c +: 2]) == l) return c;
    return -1;
  endfunction
  task automatic issue(input logic wr, input logic gp, input logic ia, input logic [21:0] a, input logic [15:0] wd);
    @(negedge clk);
    busreq = 1; buswr = wr; busgp = gp; busirq = ia; busaddr = a; buswdata = wd;
    @(negedge clk);
    busreq = 0; buswr = 0; busgp = 0; busirq = 0;
  endtask
  task automatic pulse_irq(input logic [NIRQ-1:0] m);
    @(negedge clk);
    irq = m;
    @(negedge clk);
    irq = '0;
    for (int c = 0; c < NIRQ; c++) if (m[c]) pend[c] = 1;
    @(negedge clk);
    n_chk++; if (j11irq !== lvl_exp()) begin n_fail++; $display("FAIL irq_lines got %b exp %b", j11irq, lvl_exp()); end
  endtask
  task automatic do_iack(input int l);
    int w;
    logic [15:0] e;
    w = winner(l);
    e = w < 0 ? 16'd0 : 16'(IRQVEC[9*w +: 9]);
    issue(0, 0, 1, 22'(1 << l), 0);
    if (w >= 0) pend[w] = 0;
    n_chk++; if (busack !== 1'b1 || busrdata !== e) begin n_fail++; $display("FAIL iack_vec lvl %0d got ack %b data %o exp data %o", l, busack, busrdata, e); end
    @(negedge clk);
    n_chk++; if (j11irq !== lvl_exp()) begin n_fail++; $display("FAIL iack_lines got %b exp %b", j11irq, lvl_exp()); end
  endtask
  task automatic test_reset();
    rstn = 0;
    repeat (3) @(negedge clk);
    n_chk++; if ({busack, buserr, memreq, devreq, odt, busrst} !== {4'b0000, 1'b0, 1'b1} || busrdata !== 16'd0 || j11irq !== 4'd0) begin
      n_fail++; $display("FAIL reset_state got ack %b err %b memreq %b devreq %b odt %b busrst %b rdata %o j11irq %b", busack, buserr, memreq, devreq, odt, busrst, busrdata, j11irq);
    end
    rstn = 1;
    @(negedge clk);
  endtask
  task automatic test_mem(input logic [21:0] a, input int dly, input logic [15:0] d);
    issue(0, 0, 0, a, 0);
    n_chk++; if (memreq !== 1'b1 || devreq !== '0 || busack !== 1'b0) begin n_fail++; $display("FAIL mem_req got memreq %b devreq %b ack %b exp 1 0 0", memreq, devreq, busack); end
    for (int k = 0; k < dly; k++) begin
      busreq = k == 0; busaddr = 22'o17770000;
      @(negedge clk);
      busreq = 0;
      n_chk++; if (memreq !== 1'b0 || busack !== 1'b0) begin n_fail++; $display("FAIL mem_wait got memreq %b ack %b exp 0 0", memreq, busack); end
    end
    memack = 1; memrdata = d;
    @(negedge clk);
    memack = 0; memrdata = 16'($urandom);
    n_chk++; if (busack !== 1'b1 || buserr !== 1'b0 || busrdata !== d) begin n_fail++; $display("FAIL mem_ack got ack %b err %b data %o exp 1 0 %o", busack, buserr, busrdata, d); end
    @(negedge clk);
    n_chk++; if (busack !== 1'b0 || busrdata !== d) begin n_fail++; $display("FAIL mem_hold got ack %b data %o exp 0 %o", busack, busrdata, d); end
  endtask
  task automatic test_dev();
    for (int it = 0; it < 4; it++) begin
      int s, sl, dly;
      logic [21:0] a;
      logic [15:0] d;
      logic [NDEV-1:0] e;
      s = $urandom_range(0, NDEV - 1);
      a = IOB + 22'((DEVBASE[13*s +: 13] >> 5) << 5) + 22'($urandom_range(0, 31));
      sl = slot_of(a);
      e = '0; e[sl] = 1'b1;
      dly = $urandom_range(0, 4);
      d = 16'($urandom);
      issue(0, 0, 0, a, 0);
      n_chk++; if (devreq !== e || memreq !== 1'b0 || devaddr !== a[4:1]) begin n_fail++; $display("FAIL dev_req got devreq %b memreq %b devaddr %h exp %b 0 %h", devreq, memreq, devaddr, e, a[4:1]); end
      for (int k = 0; k < dly; k++) begin
        devack = ~e; devrdata = {$urandom, $urandom};
        @(negedge clk);
        n_chk++; if (busack !== 1'b0 || devreq !== '0) begin n_fail++; $display("FAIL dev_other_ack got ack %b devreq %b exp 0 0", busack, devreq); end
      end
      devack = e; devrdata = {$urandom, $urandom}; devrdata[16*sl +: 16] = d;
      @(negedge clk);
      devack = '0;
      n_chk++; if (busack !== 1'b1 || buserr !== 1'b0 || busrdata !== d) begin n_fail++; $display("FAIL dev_ack got ack %b err %b data %o exp 1 0 %o", busack, buserr, busrdata, d); end
    end
  endtask
  task automatic test_timeout();
    int k;
    logic [NDEV-1:0] e;
    e = '0; e[slot_of(22'o17777560)] = 1'b1;
    issue(0, 0, 0, 22'o17777560, 0);
    n_chk++; if (devreq !== e) begin n_fail++; $display("FAIL to_req got %b exp %b", devreq, e); end
    k = 0;
    while (busack !== 1'b1 && k < TIMEOUT + 8) begin @(negedge clk); k++; end
    n_chk++; if (k != TIMEOUT || buserr !== 1'b1) begin n_fail++; $display("FAIL to_delay got %0d cycles err %b exp %0d 1", k, buserr, TIMEOUT); end
    @(negedge clk);
    n_chk++; if (busack !== 1'b0 || buserr !== 1'b0) begin n_fail++; $display("FAIL to_pulse got ack %b err %b exp 0 0", busack, buserr); end
  endtask
  task automatic test_buserr();
    for (int it = 0; it < 4; it++) begin
      logic [21:0] a;
      a = 22'o17770000;
      if (it > 0) do a = IOB + 22'($urandom_range(0, 8191) & ~1); while (slot_of(a) >= 0);
      issue(0, 0, 0, a, 0);
      n_chk++; if (busack !== 1'b1 || buserr !== 1'b1 || memreq !== 1'b0 || devreq !== '0) begin n_fail++; $display("FAIL nxm addr %o got ack %b err %b memreq %b devreq %b exp 1 1 0 0", a, busack, buserr, memreq, devreq); end
      @(negedge clk);
      n_chk++; if (busack !== 1'b0 || buserr !== 1'b0) begin n_fail++; $display("FAIL nxm_pulse got ack %b err %b exp 0 0", busack, buserr); end
    end
  endtask
  task automatic test_gp();
    logic [7:0] codes [5];
    codes = '{8'o214, 8'o34, 8'o14, 8'o234, 8'o0};
    for (int it = 0; it < 14; it++) begin
      logic [7:0] c;
      logic wr;
      c = it < 3 ? codes[it == 2 ? 4 : it] : ($urandom_range(0, 5) == 5 ? 8'($urandom) : codes[$urandom_range(0, 4)]);
      wr = it < 2 ? 1'b1 : it == 2 ? 1'b0 : 1'($urandom);
      issue(wr, 1, 0, {14'd0, c}, 16'($urandom));
      if (wr && c == 8'o14) m_rst = 1;
      if (wr && c == 8'o214) m_rst = 0;
      if (wr && c == 8'o34) m_odt = 1;
      if (wr && c == 8'o234) m_odt = 0;
      n_chk++; if (busack !== 1'b1 || busrst !== m_rst || odt !== m_odt) begin n_fail++; $display("FAIL gp code %o wr %b got ack %b busrst %b odt %b exp 1 %b %b", c, wr, busack, busrst, odt, m_rst, m_odt); end
      if (!wr && c == 8'o0) begin
        n_chk++; if (busrdata !== 16'o3) begin n_fail++; $display("FAIL gp_pwrup got %o exp 3", busrdata); end
      end
    end
  endtask
  task automatic test_irq();
    pulse_irq(4'b0011);
    n_chk++; if (j11irq !== 4'b0001) begin n_fail++; $display("FAIL irq_br4 got %b exp 0001", j11irq); end
    do_iack(0);
    do_iack(0);
    do_iack(0);
    pulse_irq(4'b0100);
    @(negedge clk);
    busreq = 1; busirq = 1; busaddr = 22'b0010; irq = 4'b0100;
    @(negedge clk);
    busreq = 0; busirq = 0; irq = '0;
    n_chk++; if (busack !== 1'b1 || busrdata !== 16'(IRQVEC[18 +: 9])) begin n_fail++; $display("FAIL iack_reedge got ack %b data %o exp 1 %o", busack, busrdata, IRQVEC[18 +: 9]); end
    @(negedge clk);
    n_chk++; if (j11irq !== lvl_exp()) begin n_fail++; $display("FAIL reedge_lines got %b exp %b", j11irq, lvl_exp()); end
    do_iack(1);
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 1) pulse_irq(NIRQ'($urandom));
      else do_iack($urandom_range(0, 3));
    end
  endtask
  task automatic test_reset_mid();
    pulse_irq(4'b1101);
    issue(1, 1, 0, 22'o34, 0);
    m_odt = 1;
    issue(0, 0, 0, 22'o002000, 0);
    @(negedge clk);
    rstn = 0;
    #1;
    n_chk++; if (busack !== 1'b0 || memreq !== 1'b0 || busrst !== 1'b1 || odt !== 1'b0 || j11irq !== 4'd0) begin n_fail++; $display("FAIL mid_reset got ack %b memreq %b busrst %b odt %b j11irq %b exp 0 0 1 0 0", busack, memreq, busrst, odt, j11irq); end
    repeat (2) @(negedge clk);
    rstn = 1;
    for (int c = 0; c < NIRQ; c++) pend[c] = 0;
    m_rst = 1; m_odt = 0;
    memack = 1; memrdata = 16'o7777;
    @(negedge clk);
    memack = 0;
    @(negedge clk);
    n_chk++; if (busack !== 1'b0) begin n_fail++; $display("FAIL mid_reset_noack got %b exp 0", busack); end
    for (int l = 0; l < 4; l++) do_iack(l);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_mem(22'o001000, 3, 16'($urandom));
    for (int i = 0; i < 4; i++) test_mem(22'($urandom_range(0, 22'o17757776)), $urandom_range(0, 5), 16'($urandom));
    test_dev();
    test_timeout();
    test_buserr();
    test_gp();
    test_irq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
